multimode_counter: RTL
======================

# multimode_counter

Parametrised synchronous binary counter: successor to the fixed 4-bit wrap counter, generalised in width and modulus. Adds count enable, parallel load, runtime-selectable up/down/ping-pong/hold modes, optional saturation, and a registered terminal-count pulse. Used as a general-purpose timer, address and sequence generator in the digital-circuits library.

## Interface
- WIDTH, 4, counter width in bits (≥1)
- MODULUS, 16, count range 0..MODULUS-1; legal 2 ≤ MODULUS ≤ 2^WIDTH
- SATURATE, 0, 1 = up/down modes stop at the limit instead of wrapping (ping-pong unaffected)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (sampled on clk rising edge)
- en  input  1  count enable
- load  input  1  parallel load strobe
- load_val  input  WIDTH  value to load
- mode  input  2  00 up, 01 down, 10 ping-pong, 11 hold
- q  output  WIDTH  current count (registered)
- dir  output  1  current direction, 1 = up (registered)
- tc  output  1  terminal-count pulse (registered)

## Operation
- Priority per edge: reset > load > en. All outputs are registers; no combinational paths from inputs to outputs.
- reset low: q=0, dir=1, tc=0.
- load high: q = load_val if load_val < MODULUS, otherwise MODULUS-1 (clamp). dir and mode are unaffected; tc=0.
- en low (no load): q and dir hold; tc=0.
- en high, mode 00 (up): dir forced to 1.
  - q < MODULUS-1: q+1, tc=0.
  - q == MODULUS-1: q=0 (SATURATE=0) or hold (SATURATE=1); tc=1 either way.
- en high, mode 01 (down): dir forced to 0.
  - q > 0: q-1, tc=0.
  - q == 0: q=MODULUS-1 (SATURATE=0) or hold (SATURATE=1); tc=1.
- en high, mode 10 (ping-pong): two-state direction FSM, UP (dir=1) and DOWN (dir=0).
  - UP, q < MODULUS-1: q+1.
  - UP, q == MODULUS-1: q=MODULUS-2, go DOWN, tc=1.
  - DOWN, q > 0: q-1.
  - DOWN, q == 0: q=1, go UP, tc=1.
  - MODULUS=2 toggles 0/1, with tc=1 on every step.
- en high, mode 11 (hold): q and dir hold; tc=0.
- Mode change mid-count takes effect on the next enabled edge. Ping-pong resumes from the current q in the current dir.
- Arithmetic is done at WIDTH bits; no value ≥ MODULUS can ever appear on q. When MODULUS = 2^WIDTH, natural overflow must match the wrap rule.

## Timing
- Latency 1 cycle: q, dir and tc reflect the inputs sampled at the preceding rising edge.
- tc is high for exactly one cycle per wrap, bounce or saturated step. With SATURATE=1 and en held at the limit, tc stays high every enabled cycle.
- load or reset asserted together with a limit step suppresses that step's tc.
- Reset asserted mid-count takes effect at the next edge regardless of en, load or mode.

## Structure
- Package multimode_counter_pkg holds the mode encodings (MODE_UP, MODE_DOWN, MODE_PINGPONG, MODE_HOLD) and the direction constants (DIR_UP, DIR_DOWN).
- One natural sub-module, multimode_counter_next: combinational next-q/next-dir/tc computation from q, dir, mode and parameters. The top level holds the registers, reset, load clamp and priority.
- Parameter legality (MODULUS range) is checked at elaboration.

## Test plan
- WIDTH=4, MODULUS=16, mode=00, en=1 from reset → q 0..15, then 0; tc=1 only in the cycle q shows 0 after 15.
- WIDTH=4, MODULUS=10, mode=01, load_val=3 → q 3,2,1,0,9,8; tc=1 with q=9. Repeat with SATURATE=1 → q holds at 0, tc=1 each enabled cycle.
- MODULUS=5, mode=10 → q 0,1,2,3,4,3,2,1,0,1; tc=1 with q=3 (dir=0) and with q=1 (dir=1).
- MODULUS=10, load=1 with load_val=12 → q=9, tc=0. The same edge with en=1 and q=9 in mode 00 shows no wrap and no tc.
- Counting at q=7, then reset=0 for one edge while en=1 and load=1 → q=0, dir=1, tc=0. Counting resumes from 0 on the next edge.
- Mode 00 at q=6, switch to 11 for 3 cycles then to 01 → q holds at 6, then 5 with dir=0; en=0 at any point freezes q and forces tc=0.

Source files
------------

// File: rtl/multimode_counter_pkg.sv
// Shared encodings for the multimode counter: count modes and direction states.
package multimode_counter_pkg;

    // Count mode selected on the mode input.
    typedef enum logic [1:0] {
        MODE_UP       = 2'b00,
        MODE_DOWN     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    // Counting direction; also the state of the ping-pong direction FSM.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage : multimode_counter_pkg

// File: rtl/multimode_counter_if.sv
// Control/status bundle of the multimode counter. The master drives the
// controls and observes the count; the slave is the counter itself.
interface multimode_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [1:0]       mode;
    logic [WIDTH-1:0] q;
    logic             dir;
    logic             tc;

    modport master (output en, load, load_val, mode, input q, dir, tc);
    modport slave  (input en, load, load_val, mode, output q, dir, tc);
endinterface : multimode_counter_if

// File: rtl/multimode_counter_next.sv
// Combinational successor of the counter state for one enabled step:
// next count, next direction and the terminal-count flag.
module multimode_counter_next
    import multimode_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] i_q,
    input  dir_e             i_dir,
    input  mode_e            i_mode,
    output logic [WIDTH-1:0] o_q,
    output dir_e             o_dir,
    output logic             o_tc
);
    localparam logic [WIDTH-1:0] ZERO   = '0;
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] LIM    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] LIM_M2 = WIDTH'(MODULUS - 2);

    // Step rules per mode; the limit tests use >= on the top end so that an
    // out-of-range count can never be carried forward.
    always_comb begin
        o_q   = i_q;
        o_dir = i_dir;
        o_tc  = 1'b0;
        case (i_mode)
            MODE_UP: begin
                o_dir = DIR_UP;
                if (i_q >= LIM) begin
                    o_tc = 1'b1;
                    if (SATURATE != 0) begin
                        o_q = i_q;
                    end else begin
                        o_q = ZERO;
                    end
                end else begin
                    o_q = i_q + ONE;
                end
            end
            MODE_DOWN: begin
                o_dir = DIR_DOWN;
                if (i_q == ZERO) begin
                    o_tc = 1'b1;
                    if (SATURATE != 0) begin
                        o_q = i_q;
                    end else begin
                        o_q = LIM;
                    end
                end else begin
                    o_q = i_q - ONE;
                end
            end
            MODE_PINGPONG: begin
                if (i_dir == DIR_UP) begin
                    if (i_q >= LIM) begin
                        o_q   = LIM_M2;
                        o_dir = DIR_DOWN;
                        o_tc  = 1'b1;
                    end else begin
                        o_q = i_q + ONE;
                    end
                end else begin
                    if (i_q == ZERO) begin
                        o_q   = ONE;
                        o_dir = DIR_UP;
                        o_tc  = 1'b1;
                    end else begin
                        o_q = i_q - ONE;
                    end
                end
            end
            MODE_HOLD: begin
                o_q   = i_q;
                o_dir = i_dir;
                o_tc  = 1'b0;
            end
            default: begin
                o_q   = i_q;
                o_dir = i_dir;
                o_tc  = 1'b0;
            end
        endcase
    end
endmodule : multimode_counter_next

// File: rtl/multimode_counter.sv
// Parametrised up/down/ping-pong/hold counter with enable, clamped parallel
// load, optional saturation and a registered terminal-count pulse.
module multimode_counter
    import multimode_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                reset,
    multimode_counter_if.slave  bus
);
    generate
        if (WIDTH < 1 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_param
            $error("multimode_counter: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] LIM     = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    dir_e             r_dir;
    logic             r_tc;

    logic [WIDTH-1:0] w_q_nxt;
    dir_e             w_dir_nxt;
    logic             w_tc_nxt;
    logic [WIDTH-1:0] w_load_q;

    multimode_counter_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .i_q    (r_q),
        .i_dir  (r_dir),
        .i_mode (mode_e'(bus.mode)),
        .o_q    (w_q_nxt),
        .o_dir  (w_dir_nxt),
        .o_tc   (w_tc_nxt)
    );

    // Clamp the load value into the legal count range (compare one bit wider
    // so MODULUS == 2**WIDTH needs no special case).
    always_comb begin
        w_load_q = LIM;
        if ({1'b0, bus.load_val} < MOD_EXT) begin
            w_load_q = bus.load_val;
        end else begin
            w_load_q = LIM;
        end
    end

    // State registers with priority reset > load > enable; tc only follows a step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q   <= '0;
            r_dir <= DIR_UP;
            r_tc  <= 1'b0;
        end else if (bus.load) begin
            r_q   <= w_load_q;
            r_tc  <= 1'b0;
        end else if (bus.en) begin
            r_q   <= w_q_nxt;
            r_dir <= w_dir_nxt;
            r_tc  <= w_tc_nxt;
        end else begin
            r_tc  <= 1'b0;
        end
    end

    assign bus.q   = r_q;
    assign bus.dir = r_dir;
    assign bus.tc  = r_tc;
endmodule : multimode_counter
